first_done_collector: RTL and testbench

//  Dispatches one job to N_WORKERS parallel workers and takes whichever finishes first.
//  It forwards that result upstream and kills the losing workers.
//  A watchdog ends the race if no worker finishes within TIMEOUT cycles.

---
 rtl/first_done_collector_if.sv | 39 +++
 rtl/first_done_collector.sv | 152 +++++++++++++++
 tb/tb_first_done_collector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/first_done_collector_if.sv
// -----------------------------------------------------------------------------
// first_done_collector_if
//  Bundles the requester handshake, the worker launch/kill/done lines and the
//  response handshake of first_done_collector.
//  slave  : the collector's view (drives req_ready, launch*, kill, resp_*)
//  master : the environment's view (drives req_*, wk_*, resp_ready)
// -----------------------------------------------------------------------------
interface first_done_collector_if #(
   parameter int N_WORKERS = 2,
   parameter int DATA_W    = 4
);
   localparam int SRC_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;

   logic                          req_valid;
   logic                          req_ready;
   logic [DATA_W-1:0]             req_data;
   logic [N_WORKERS-1:0]          launch;
   logic [DATA_W-1:0]             launch_data;
   logic [N_WORKERS-1:0]          wk_done;
   logic [N_WORKERS*DATA_W-1:0]   wk_data;
   logic [N_WORKERS-1:0]          kill;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [DATA_W-1:0]             resp_data;
   logic [SRC_W-1:0]              resp_src;
   logic                          resp_timeout;

   modport slave (
      input  req_valid, req_data, wk_done, wk_data, resp_ready,
      output req_ready, launch, launch_data, kill,
             resp_valid, resp_data, resp_src, resp_timeout
   );

   modport master (
      output req_valid, req_data, wk_done, wk_data, resp_ready,
      input  req_ready, launch, launch_data, kill,
             resp_valid, resp_data, resp_src, resp_timeout
   );
endinterface

// File: rtl/first_done_collector.sv
// -----------------------------------------------------------------------------
// first_done_collector
//  Dispatches one job to N_WORKERS redundant workers, forwards the result of
//  the first (lowest-index on ties) worker to finish, and kills the losers.
//  A watchdog aborts the race after TIMEOUT RUN cycles and kills everyone.
// Ports
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset (drops any job in flight, no kill)
//  bus  : first_done_collector_if.slave
//         req_valid/req_ready/req_data      job request handshake
//         launch/launch_data                start pulse and held job payload
//         wk_done/wk_data                   per-worker completion and result
//         kill                              abort pulse to losing workers
//         resp_valid/resp_ready             response handshake
//         resp_data/resp_src/resp_timeout   winning result, index, watchdog flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module first_done_collector #(
   parameter int N_WORKERS = 2,
   parameter int DATA_W    = 4,
   parameter int TIMEOUT   = 15
) (
   input logic                  clk,
   input logic                  rst,
   first_done_collector_if.slave bus
);
   localparam int SRC_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
   localparam int TM_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_KILL   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t                state_r;
   logic [TM_W-1:0]       timer_r;
   logic                  req_ready_r;
   logic [N_WORKERS-1:0]  launch_r;
   logic [DATA_W-1:0]     launch_data_r;
   logic [N_WORKERS-1:0]  kill_r;
   logic                  resp_valid_r;
   logic [DATA_W-1:0]     resp_data_r;
   logic [SRC_W-1:0]      resp_src_r;
   logic                  resp_timeout_r;

   logic                  any_done_s;
   logic [SRC_W-1:0]      win_idx_s;
   logic [DATA_W-1:0]     win_data_s;
   logic [N_WORKERS-1:0]  loser_mask_s;

   // Lowest-index priority pick of the finishing worker and its result.
   always_comb begin
      any_done_s = |bus.wk_done;
      win_idx_s  = {SRC_W{1'b0}};
      // Scan downward so the lowest set index is the last one written.
      for (int i = N_WORKERS - 1; i >= 0; i--) begin
         win_idx_s = bus.wk_done[i] ? SRC_W'(i) : win_idx_s;
      end
      win_data_s   = bus.wk_data[win_idx_s*DATA_W +: DATA_W];
      loser_mask_s = ~(N_WORKERS'(1) << win_idx_s);
   end

   // Race controller FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         timer_r        <= {TM_W{1'b0}};
         req_ready_r    <= 1'b1;
         launch_r       <= {N_WORKERS{1'b0}};
         launch_data_r  <= {DATA_W{1'b0}};
         kill_r         <= {N_WORKERS{1'b0}};
         resp_valid_r   <= 1'b0;
         resp_data_r    <= {DATA_W{1'b0}};
         resp_src_r     <= {SRC_W{1'b0}};
         resp_timeout_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               kill_r <= {N_WORKERS{1'b0}};
               if (bus.req_valid) begin
                  // Launch pulse is raised on the accept edge so it is high
                  // for exactly the LAUNCH cycle.
                  launch_data_r <= bus.req_data;
                  launch_r      <= {N_WORKERS{1'b1}};
                  req_ready_r   <= 1'b0;
                  state_r       <= ST_LAUNCH;
               end else begin
                  launch_r    <= {N_WORKERS{1'b0}};
                  req_ready_r <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               launch_r <= {N_WORKERS{1'b0}};
               timer_r  <= {TM_W{1'b0}};
               state_r  <= ST_RUN;
            end
            ST_RUN: begin
               // A done wins over a watchdog expiry in the same cycle.
               if (any_done_s) begin
                  resp_data_r    <= win_data_s;
                  resp_src_r     <= win_idx_s;
                  resp_timeout_r <= 1'b0;
                  kill_r         <= loser_mask_s;
                  state_r        <= ST_KILL;
               end else if (timer_r == TM_W'(TIMEOUT - 1)) begin
                  resp_data_r    <= {DATA_W{1'b0}};
                  resp_src_r     <= {SRC_W{1'b0}};
                  resp_timeout_r <= 1'b1;
                  kill_r         <= {N_WORKERS{1'b1}};
                  state_r        <= ST_KILL;
               end else begin
                  timer_r <= timer_r + TM_W'(1);
               end
            end
            ST_KILL: begin
               kill_r       <= {N_WORKERS{1'b0}};
               resp_valid_r <= 1'b1;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               // Result is frozen here; wk_done is not looked at.
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state_r      <= ST_IDLE;
               end else begin
                  resp_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               launch_r     <= {N_WORKERS{1'b0}};
               kill_r       <= {N_WORKERS{1'b0}};
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready    = req_ready_r;
   assign bus.launch       = launch_r;
   assign bus.launch_data  = launch_data_r;
   assign bus.kill         = kill_r;
   assign bus.resp_valid   = resp_valid_r;
   assign bus.resp_data    = resp_data_r;
   assign bus.resp_src     = resp_src_r;
   assign bus.resp_timeout = resp_timeout_r;
endmodule

// File: tb/tb_first_done_collector.sv
module tb_first_done_collector;
   logic clk;
   logic rst;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [3:0] data;
      logic       src;
      logic       tmo;
   } resp_t;

   resp_t      resp_q[$];
   logic [1:0] kill_q[$];

   first_done_collector_if #(.N_WORKERS(2), .DATA_W(4)) bus ();

   first_done_collector #(.N_WORKERS(2), .DATA_W(4), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Response scoreboard monitor.
   always @(negedge clk) begin
      if (bus.resp_valid && bus.resp_ready) begin
         if (resp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
         end else begin
            resp_t e;
            e = resp_q.pop_front();
            chk("resp_data", 32'(bus.resp_data), 32'(e.data));
            chk("resp_src", 32'(bus.resp_src), 32'(e.src));
            chk("resp_timeout", 32'(bus.resp_timeout), 32'(e.tmo));
         end
      end
   end

   // Kill pulse scoreboard monitor.
   always @(negedge clk) begin
      if (bus.kill != 2'b00) begin
         if (kill_q.size() == 0) begin
            chk("kill_unexpected", 32'(bus.kill), 32'd0);
         end else begin
            logic [1:0] k;
            k = kill_q.pop_front();
            chk("kill", 32'(bus.kill), 32'(k));
            chk("kill_launch_overlap", 32'(bus.launch), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // c: RUN cycle on which done is driven (0 = never); hold: resp_ready low cycles.
   task automatic run_job(input logic [3:0] req, input int c, input logic [1:0] mask,
                          input logic [3:0] d0, input logic [3:0] d1, input int hold,
                          input logic [3:0] exp_d, input logic exp_s, input logic exp_t,
                          input logic [1:0] exp_k);
      resp_t r;
      bit    seen;
      r.data = exp_d; r.src = exp_s; r.tmo = exp_t;
      resp_q.push_back(r);
      kill_q.push_back(exp_k);
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_data  = req;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("launch", 32'(bus.launch), 32'd3);
      chk("launch_data", 32'(bus.launch_data), 32'(req));
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (c > 0) begin
         repeat (c) @(posedge clk);
         #1;
         bus.wk_done = mask;
         bus.wk_data = {d1, d0};
         @(posedge clk); #1;
         bus.wk_done = 2'b00;
         bus.wk_data = 8'h00;
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.resp_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("resp_valid_seen", 32'(seen), 32'd1);
      for (int i = 0; i < hold; i++) begin
         chk("bp_data", 32'(bus.resp_data), 32'(exp_d));
         chk("bp_src", 32'(bus.resp_src), 32'(exp_s));
         chk("bp_valid", 32'(bus.resp_valid), 32'd1);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         if (i == 1) begin
            bus.wk_done = 2'b11;
            bus.wk_data = 8'hFF;
         end else begin
            bus.wk_done = 2'b00;
            bus.wk_data = 8'h00;
         end
         @(posedge clk); #1;
      end
      bus.wk_done    = 2'b00;
      bus.wk_data    = 8'h00;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk("resp_valid_cleared", 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_data   = 4'd0;
      bus.wk_done    = 2'b00;
      bus.wk_data    = 8'h00;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_launch", 32'(bus.launch), 32'd0);
      chk("rst_kill", 32'(bus.kill), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // req, c, mask, d0, d1, hold, exp data, exp src, exp timeout, exp kill
      run_job(4'd3,  2,  2'b10, 4'd5, 4'd13, 0, 4'd13, 1'b1, 1'b0, 2'b01); // single winner
      run_job(4'd1,  3,  2'b11, 4'd8, 4'd11, 0, 4'd8,  1'b0, 1'b0, 2'b10); // tie
      run_job(4'd6,  0,  2'b00, 4'd0, 4'd0,  0, 4'd0,  1'b0, 1'b1, 2'b11); // timeout
      run_job(4'd10, 15, 2'b01, 4'd6, 4'd2,  0, 4'd6,  1'b0, 1'b0, 2'b10); // done on 15th
      run_job(4'd5,  1,  2'b10, 4'd0, 4'd9,  5, 4'd9,  1'b1, 1'b0, 2'b01); // backpressure
      run_job(4'd2,  1,  2'b01, 4'd7, 4'd1,  0, 4'd7,  1'b0, 1'b0, 2'b10); // back-to-back

      // Reset one cycle after launch: job dropped, no kill, no response.
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd12;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstrun_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rstrun_launch", 32'(bus.launch), 32'd0);
      for (int i = 0; i < 6; i++) begin
         chk("rstrun_no_resp", 32'(bus.resp_valid), 32'd0);
         chk("rstrun_no_kill", 32'(bus.kill), 32'd0);
         @(posedge clk); #1;
      end

      run_job(4'd4,  1,  2'b01, 4'd14, 4'd3, 0, 4'd14, 1'b0, 1'b0, 2'b10); // recovery

      repeat (3) @(posedge clk);
      #1;
      chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      chk("kill_q_empty", 32'(kill_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
